// File: rtl/sparse_chunk_packer_pkg.sv
// Shared sizing constants, helpers and FSM state type for the sparse chunk packer.
package sparse_pkg;

  localparam int unsigned DEF_BUS_SIZE    = 32;
  localparam int unsigned DEF_DAT_SIZE    = 8;
  localparam int unsigned DEF_CHUNK_BEATS = 4;
  localparam int unsigned DEF_CHUNK_NUM   = 16;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } pack_state_e;

  // Width of an index over 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a count over 0..n inclusive.
  function automatic int unsigned num_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_DCNT_W = cnt_width(DEF_CHUNK_BEATS);
  localparam int unsigned DEF_CCNT_W = cnt_width(DEF_CHUNK_NUM);
  localparam int unsigned DEF_NZ_W   = num_width(DEF_CHUNK_BEATS * DEF_BUS_SIZE);

endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational compactor: nonzero map, left-packed nonzero elements and popcount
// for one dense beat.
module sparse_beat_compactor
  import sparse_pkg::*;
#(
  parameter int unsigned BUS_SIZE = DEF_BUS_SIZE,
  parameter int unsigned DAT_SIZE = DEF_DAT_SIZE,
  parameter int unsigned POP_W    = 6
) (
  input  logic [BUS_SIZE*DAT_SIZE-1:0] beat_i,
  output logic [BUS_SIZE-1:0]          map_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0] packed_o,
  output logic [POP_W-1:0]             pop_o
);

  // pos[e] = number of nonzero elements strictly below element e
  logic [POP_W-1:0] pos [BUS_SIZE+1];

  always_comb begin
    map_o    = '0;
    packed_o = '0;
    pos      = '{default: '0};
    for (int unsigned e = 0; e < BUS_SIZE; e++) begin
      map_o[e]   = |beat_i[e*DAT_SIZE +: DAT_SIZE];
      pos[e + 1] = pos[e] + POP_W'(map_o[e]);
    end
    for (int unsigned e = 0; e < BUS_SIZE; e++) begin
      if (map_o[e]) begin
        packed_o[32'(pos[e])*DAT_SIZE +: DAT_SIZE] = beat_i[e*DAT_SIZE +: DAT_SIZE];
      end
    end
    pop_o = pos[BUS_SIZE];
  end

endmodule

// File: rtl/sparse_chunk_packer.sv
// Dense-to-sparse chunk packer: fills one chunk of map slices and packed nonzeros,
// then drains it as CHUNK_BEATS write beats under valid/ready.
module sparse_chunk_packer
  import sparse_pkg::*;
#(
  parameter int unsigned BUS_SIZE    = DEF_BUS_SIZE,
  parameter int unsigned DAT_SIZE    = DEF_DAT_SIZE,
  parameter int unsigned CHUNK_BEATS = DEF_CHUNK_BEATS,
  parameter int unsigned CHUNK_NUM   = DEF_CHUNK_NUM
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [BUS_SIZE*DAT_SIZE-1:0]                in_data_i,
  input  logic                                        in_valid_i,
  input  logic                                        in_last_i,
  output logic                                        in_ready_o,
  output logic [BUS_SIZE-1:0]                         wr_sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0]                wr_nonzero_data_o,
  output logic                                        wr_valid_o,
  input  logic                                        wr_ready_i,
  output logic                                        wr_last_o,
  output logic [cnt_width(CHUNK_BEATS)-1:0]           wr_dat_count_o,
  output logic [cnt_width(CHUNK_NUM)-1:0]             wr_chunk_count_o,
  output logic [num_width(CHUNK_BEATS*BUS_SIZE)-1:0]  chunk_nz_count_o,
  input  logic                                        chunk_cnt_clr_i,
  output logic                                        chunk_done_o
);

  localparam int unsigned BEAT_W = BUS_SIZE * DAT_SIZE;
  localparam int unsigned ELEMS  = CHUNK_BEATS * BUS_SIZE;
  localparam int unsigned DCNT_W = cnt_width(CHUNK_BEATS);
  localparam int unsigned CCNT_W = cnt_width(CHUNK_NUM);
  localparam int unsigned NZ_W   = num_width(ELEMS);
  localparam int unsigned FILL_W = num_width(CHUNK_BEATS);
  localparam int unsigned POP_W  = num_width(BUS_SIZE);
  localparam int unsigned ELEM_W = cnt_width(ELEMS);

  pack_state_e         state_q, state_d;
  logic [FILL_W-1:0]   fill_idx_q, fill_idx_d;
  logic [NZ_W-1:0]     nz_ptr_q, nz_ptr_d;
  logic [NZ_W-1:0]     nz_cnt_q, nz_cnt_d;
  logic [DCNT_W-1:0]   dat_cnt_q, dat_cnt_d;
  logic [CCNT_W-1:0]   chunk_cnt_q, chunk_cnt_d;
  logic                done_q, done_d;
  logic                wr_last_q, wr_last_d;
  logic [BUS_SIZE-1:0] wr_map_q, wr_map_d;
  logic [BEAT_W-1:0]   wr_dat_q, wr_dat_d;

  logic [BUS_SIZE-1:0] map_buf_q  [CHUNK_BEATS];
  logic [BUS_SIZE-1:0] map_buf_d  [CHUNK_BEATS];
  logic [DAT_SIZE-1:0] pack_buf_q [ELEMS];
  logic [DAT_SIZE-1:0] pack_buf_d [ELEMS];

  logic [BUS_SIZE-1:0] beat_map;
  logic [BEAT_W-1:0]   beat_packed;
  logic [POP_W-1:0]    beat_pop;

  logic        accept;
  logic        close;
  logic        wr_hs;
  logic        last_beat;
  int unsigned widx;
  int unsigned ridx;

  sparse_beat_compactor #(
    .BUS_SIZE (BUS_SIZE),
    .DAT_SIZE (DAT_SIZE),
    .POP_W    (POP_W)
  ) u_compactor (
    .beat_i   (in_data_i),
    .map_o    (beat_map),
    .packed_o (beat_packed),
    .pop_o    (beat_pop)
  );

  assign accept    = in_valid_i && (state_q == FILL);
  assign close     = accept && (in_last_i || (fill_idx_q == FILL_W'(CHUNK_BEATS - 1)));
  assign wr_hs     = (state_q == DRAIN) && wr_ready_i;
  assign last_beat = (dat_cnt_q == DCNT_W'(CHUNK_BEATS - 1));

  always_comb begin
    state_d     = state_q;
    fill_idx_d  = fill_idx_q;
    nz_ptr_d    = nz_ptr_q;
    nz_cnt_d    = nz_cnt_q;
    dat_cnt_d   = dat_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    done_d      = 1'b0;
    map_buf_d   = map_buf_q;
    pack_buf_d  = pack_buf_q;
    widx        = 0;

    if (accept) begin
      map_buf_d[DCNT_W'(fill_idx_q)] = beat_map;
      // Element-granular append; only the popcount lanes are written.
      for (int unsigned j = 0; j < BUS_SIZE; j++) begin
        widx = 32'(nz_ptr_q) + j;
        if ((j < 32'(beat_pop)) && (widx < ELEMS)) begin
          pack_buf_d[ELEM_W'(widx)] = beat_packed[j*DAT_SIZE +: DAT_SIZE];
        end
      end
      nz_ptr_d   = nz_ptr_q + NZ_W'(beat_pop);
      fill_idx_d = fill_idx_q + FILL_W'(1);
    end

    if (close) begin
      state_d   = DRAIN;
      dat_cnt_d = '0;
      nz_cnt_d  = nz_ptr_d;
    end

    if (wr_hs) begin
      if (last_beat) begin
        state_d     = FILL;
        dat_cnt_d   = '0;
        fill_idx_d  = '0;
        nz_ptr_d    = '0;
        done_d      = 1'b1;
        chunk_cnt_d = (chunk_cnt_q == CCNT_W'(CHUNK_NUM - 1)) ? '0 : chunk_cnt_q + CCNT_W'(1);
      end else begin
        dat_cnt_d = dat_cnt_q + DCNT_W'(1);
      end
    end

    if (chunk_cnt_clr_i) begin
      chunk_cnt_d = '0;
    end
  end

  // Write beat is read from next-state buffers so beat 0 includes the closing input beat.
  always_comb begin
    wr_map_d  = '0;
    wr_dat_d  = '0;
    wr_last_d = 1'b0;
    ridx      = 0;
    if (state_d == DRAIN) begin
      wr_last_d = (dat_cnt_d == DCNT_W'(CHUNK_BEATS - 1));
      if (32'(dat_cnt_d) < 32'(fill_idx_d)) begin
        wr_map_d = map_buf_d[dat_cnt_d];
      end
      for (int unsigned i = 0; i < BUS_SIZE; i++) begin
        ridx = 32'(dat_cnt_d) * BUS_SIZE + i;
        if (ridx < 32'(nz_ptr_d)) begin
          wr_dat_d[i*DAT_SIZE +: DAT_SIZE] = pack_buf_d[ELEM_W'(ridx)];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      fill_idx_q  <= '0;
      nz_ptr_q    <= '0;
      nz_cnt_q    <= '0;
      dat_cnt_q   <= '0;
      chunk_cnt_q <= '0;
      done_q      <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_map_q    <= '0;
      wr_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      nz_ptr_q    <= nz_ptr_d;
      nz_cnt_q    <= nz_cnt_d;
      dat_cnt_q   <= dat_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      done_q      <= done_d;
      wr_last_q   <= wr_last_d;
      wr_map_q    <= wr_map_d;
      wr_dat_q    <= wr_dat_d;
    end
  end

  // Buffers are never cleared; stale contents are hidden by fill_idx/nz_ptr read masks.
  always_ff @(posedge clk_i) begin
    map_buf_q  <= map_buf_d;
    pack_buf_q <= pack_buf_d;
  end

  assign in_ready_o        = (state_q == FILL);
  assign wr_valid_o        = (state_q == DRAIN);
  assign wr_sparsemap_o    = wr_map_q;
  assign wr_nonzero_data_o = wr_dat_q;
  assign wr_last_o         = wr_last_q;
  assign wr_dat_count_o    = dat_cnt_q;
  assign wr_chunk_count_o  = chunk_cnt_q;
  assign chunk_nz_count_o  = nz_cnt_q;
  assign chunk_done_o      = done_q;

endmodule

// File: tb/tb_sparse_chunk_packer.sv
// Self-checking bench for sparse_chunk_packer (BUS_SIZE=4, DAT_SIZE=8, CHUNK_BEATS=2, CHUNK_NUM=3).
module tb_sparse_chunk_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  wr_map;
  logic [31:0] wr_dat;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_last;
  logic [0:0]  wr_dat_count;
  logic [1:0]  wr_chunk_count;
  logic [3:0]  nz_count;
  logic        clr;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_chunk = 0;

  typedef struct {
    string            name;
    logic [1:0][31:0] beats;
    int unsigned      nb;
    logic [1:0][3:0]  emap;
    logic [1:0][31:0] edat;
    int unsigned      enz;
  } vec_t;

  vec_t tbl [3];

  sparse_chunk_packer #(
    .BUS_SIZE    (4),
    .DAT_SIZE    (8),
    .CHUNK_BEATS (2),
    .CHUNK_NUM   (3)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .in_data_i         (in_data),
    .in_valid_i        (in_valid),
    .in_last_i         (in_last),
    .in_ready_o        (in_ready),
    .wr_sparsemap_o    (wr_map),
    .wr_nonzero_data_o (wr_dat),
    .wr_valid_o        (wr_valid),
    .wr_ready_i        (wr_ready),
    .wr_last_o         (wr_last),
    .wr_dat_count_o    (wr_dat_count),
    .wr_chunk_count_o  (wr_chunk_count),
    .chunk_nz_count_o  (nz_count),
    .chunk_cnt_clr_i   (clr),
    .chunk_done_o      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [7:0] e0, input logic [7:0] e1,
                                     input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // Reference: collect nonzeros of the chunk in order, then cut into beat-sized slices.
  function automatic void model(input logic [1:0][31:0] beats, input int unsigned nb,
                                output logic [1:0][3:0] emap, output logic [1:0][31:0] edat,
                                output int unsigned enz);
    logic [7:0] q[$];
    logic [7:0] v;
    emap = '0;
    edat = '0;
    for (int unsigned b = 0; b < nb; b++) begin
      for (int unsigned e = 0; e < 4; e++) begin
        v = beats[b][e*8 +: 8];
        if (v != 8'd0) begin
          emap[b][e] = 1'b1;
          q.push_back(v);
        end
      end
    end
    enz = q.size();
    for (int unsigned i = 0; i < q.size(); i++) begin
      edat[i/4][(i%4)*8 +: 8] = q[i];
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"},    64'(in_ready), 64'(1));
    check({tag, " wr_valid"},    64'(wr_valid), 64'(0));
    check({tag, " wr_last"},     64'(wr_last), 64'(0));
    check({tag, " chunk_done"},  64'(done), 64'(0));
    check({tag, " sparsemap"},   64'(wr_map), 64'(0));
    check({tag, " nonzero_dat"}, 64'(wr_dat), 64'(0));
    check({tag, " dat_count"},   64'(wr_dat_count), 64'(0));
    check({tag, " chunk_count"}, 64'(wr_chunk_count), 64'(0));
    check({tag, " nz_count"},    64'(nz_count), 64'(0));
  endtask

  // Feeds one chunk, then checks every drained beat (with optional stalls) and the done pulse.
  task automatic run_chunk(input string tag, input logic [1:0][31:0] beats, input int unsigned nb,
                           input logic [1:0][3:0] emap, input logic [1:0][31:0] edat,
                           input int unsigned enz, input int unsigned st0, input int unsigned st1,
                           input bit clr_end, input int unsigned idle_last, input bit junk);
    int unsigned stall;
    for (int unsigned c = 0; c < idle_last; c++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      @(negedge clk);
      check({tag, " idle-last in_ready"}, 64'(in_ready), 64'(1));
      check({tag, " idle-last wr_valid"}, 64'(wr_valid), 64'(0));
    end
    for (int unsigned i = 0; i < nb; i++) begin
      check({tag, " fill in_ready"}, 64'(in_ready), 64'(1));
      check({tag, " fill wr_valid"}, 64'(wr_valid), 64'(0));
      in_valid = 1'b1;
      in_data  = beats[i];
      in_last  = (i == nb - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      stall = (k == 0) ? st0 : st1;
      for (int unsigned s = 0; s <= stall; s++) begin
        wr_ready = (s == stall);
        in_valid = junk;
        in_last  = junk;
        in_data  = $urandom;
        check({tag, " wr_valid"},    64'(wr_valid), 64'(1));
        check({tag, " in_ready"},    64'(in_ready), 64'(0));
        check({tag, " sparsemap"},   64'(wr_map), 64'(emap[k]));
        check({tag, " nonzero_dat"}, 64'(wr_dat), 64'(edat[k]));
        check({tag, " wr_last"},     64'(wr_last), 64'(k == 1));
        check({tag, " dat_count"},   64'(wr_dat_count), 64'(k));
        check({tag, " chunk_count"}, 64'(wr_chunk_count), 64'(exp_chunk));
        check({tag, " nz_count"},    64'(nz_count), 64'(enz));
        check({tag, " done low"},    64'(done), 64'(0));
        clr = clr_end && (k == 1) && (s == stall);
        @(negedge clk);
      end
    end
    clr      = 1'b0;
    wr_ready = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " chunk_done"},     64'(done), 64'(1));
    check({tag, " post wr_valid"},  64'(wr_valid), 64'(0));
    check({tag, " post in_ready"},  64'(in_ready), 64'(1));
    exp_chunk = clr_end ? 0 : (exp_chunk + 1) % 3;
  endtask

  initial begin
    logic [1:0][31:0] b;
    logic [1:0][3:0]  em;
    logic [1:0][31:0] ed;
    int unsigned      enz;
    int unsigned      nb;
    logic [7:0]       v;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    wr_ready = 1'b1;
    clr      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    tbl[0].name = "dense";
    tbl[0].beats[0] = mk(1, 2, 3, 4);  tbl[0].beats[1] = mk(5, 6, 7, 8);  tbl[0].nb = 2;
    tbl[0].emap[0]  = 4'hF;            tbl[0].emap[1]  = 4'hF;
    tbl[0].edat[0]  = mk(1, 2, 3, 4);  tbl[0].edat[1]  = mk(5, 6, 7, 8);  tbl[0].enz = 8;
    tbl[1].name = "cross-beat";
    tbl[1].beats[0] = mk(0, 5, 0, 7);  tbl[1].beats[1] = mk(9, 0, 0, 0);  tbl[1].nb = 2;
    tbl[1].emap[0]  = 4'b1010;         tbl[1].emap[1]  = 4'b0001;
    tbl[1].edat[0]  = mk(5, 7, 9, 0);  tbl[1].edat[1]  = '0;              tbl[1].enz = 3;
    tbl[2].name = "early-last";
    tbl[2].beats[0] = mk(0, 0, 3, 0);  tbl[2].beats[1] = '0;              tbl[2].nb = 1;
    tbl[2].emap[0]  = 4'b0100;         tbl[2].emap[1]  = 4'b0000;
    tbl[2].edat[0]  = mk(3, 0, 0, 0);  tbl[2].edat[1]  = '0;              tbl[2].enz = 1;

    // Chunk counter runs 0,1,2 over the table, then wraps to 0 on the backpressure chunk.
    for (int unsigned t = 0; t < 3; t++) begin
      run_chunk(tbl[t].name, tbl[t].beats, tbl[t].nb, tbl[t].emap, tbl[t].edat, tbl[t].enz,
                0, 0, 1'b0, 0, 1'b0);
    end

    b[0] = mk(1, 0, 2, 0);  b[1] = mk(0, 3, 0, 4);
    em[0] = 4'b0101;  em[1] = 4'b1010;  ed[0] = mk(1, 2, 3, 4);  ed[1] = '0;
    run_chunk("backpressure", b, 2, em, ed, 4, 3, 0, 1'b0, 0, 1'b1);

    b[0] = mk(0, 0, 0, 9);  b[1] = mk(8, 0, 0, 0);
    em[0] = 4'b1000;  em[1] = 4'b0001;  ed[0] = mk(9, 8, 0, 0);  ed[1] = '0;
    run_chunk("clr-at-final", b, 2, em, ed, 2, 0, 1, 1'b1, 0, 1'b0);
    run_chunk("after-clr", b, 2, em, ed, 2, 0, 0, 1'b0, 1, 1'b0);

    // Reset after one accepted beat; the stale beat must not leak into the next chunk.
    in_valid = 1'b1;
    in_data  = mk(11, 12, 13, 14);
    in_last  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("mid-fill reset");
    @(negedge clk);
    rst = 1'b0;
    exp_chunk = 0;
    @(negedge clk);
    b[0] = mk(0, 0, 0, 6);  b[1] = '0;
    em[0] = 4'b1000;  em[1] = '0;  ed[0] = mk(6, 0, 0, 0);  ed[1] = '0;
    run_chunk("post-reset", b, 1, em, ed, 1, 0, 0, 1'b0, 0, 1'b0);

    for (int unsigned r = 0; r < 60; r++) begin
      nb = $urandom_range(1, 2);
      b  = '0;
      for (int unsigned bi = 0; bi < nb; bi++) begin
        for (int unsigned e = 0; e < 4; e++) begin
          v = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          b[bi][e*8 +: 8] = v;
        end
      end
      model(b, nb, em, ed, enz);
      run_chunk($sformatf("random%0d", r), b, nb, em, ed, enz,
                $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 9) == 0),
                $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_chunk_packer.md
# sparse_chunk_packer

Synthesizable sparse-format packer that converts a dense element stream into the chunked sparsemap + packed-nonzero write format consumed by the IFM and filter SRAMs. It accepts one dense bus beat per cycle under valid/ready and builds one chunk in an internal buffer. It then drains the chunk as exactly CHUNK_BEATS write beats, with dat/chunk counters and output backpressure. It replaces the simulation-only stimulus generators on the SRAM write path and is instantiated once per SRAM type.

## Interface
- BUS_SIZE, 32, elements per beat.
- DAT_SIZE, 8, bits per element.
- CHUNK_BEATS, 4, write beats per chunk (WR_DAT_CYC_NUM).
- CHUNK_NUM, 16, chunk-counter modulus (SRAM_IFM_NUM or SRAM_FILTER_NUM).
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- in_data_i  in  BUS_SIZE*DAT_SIZE  dense beat; element e at bits [e*DAT_SIZE +: DAT_SIZE].
- in_valid_i  in  1  input beat valid.
- in_last_i  in  1  final beat of a short chunk.
- in_ready_o  out  1  input accept.
- wr_sparsemap_o  out  BUS_SIZE  map slice of the current beat; bit e = element nonzero.
- wr_nonzero_data_o  out  BUS_SIZE*DAT_SIZE  packed nonzero slice of the current beat.
- wr_valid_o  out  1  write beat valid.
- wr_ready_i  in  1  SRAM accepts beat.
- wr_last_o  out  1  current beat is beat CHUNK_BEATS-1.
- wr_dat_count_o  out  $clog2(CHUNK_BEATS)  beat index within chunk.
- wr_chunk_count_o  out  $clog2(CHUNK_NUM)  chunk index.
- chunk_nz_count_o  out  $clog2(CHUNK_BEATS*BUS_SIZE+1)  nonzeros in the draining chunk.
- chunk_cnt_clr_i  in  1  synchronous clear of the chunk counter.
- chunk_done_o  out  1  one-cycle pulse after the last beat handshake.

## Operation
- States: FILL, DRAIN. Reset state is FILL.
- in_ready_o = (state==FILL). wr_valid_o = (state==DRAIN).
- FILL, per accepted beat (in_valid_i & in_ready_o):
  - Store the map slice at beat index fill_idx.
  - Compact nonzero elements in ascending element order and append them to the packed buffer at nz_ptr.
  - Advance nz_ptr by the beat popcount and increment fill_idx.
- Chunk closes on an accepted beat with in_last_i=1 or fill_idx==CHUNK_BEATS-1, then FILL->DRAIN.
- Short chunk: map slices not written read as zero.
- Packed buffer elements at index >= nz_ptr read as zero. This is a read mask; the buffer is never bulk-cleared.
- DRAIN, beat k = wr_dat_count_o:
  - wr_sparsemap_o = map slice k.
  - wr_nonzero_data_o = packed elements [k*BUS_SIZE +: BUS_SIZE].
  - Packed data is chunk-contiguous and is not aligned to the map slice.
- All write outputs hold stable while wr_valid_o & !wr_ready_i.
- Handshake on k<CHUNK_BEATS-1: k increments.
- Handshake on k==CHUNK_BEATS-1:
  - wr_dat_count_o returns to 0.
  - wr_chunk_count_o increments; CHUNK_NUM-1 wraps to 0.
  - chunk_done_o pulses.
  - fill_idx and nz_ptr clear; DRAIN->FILL.
- chunk_cnt_clr_i sets the chunk counter to 0. It wins over a coincident increment and is legal in any state.
- in_last_i with in_valid_i=0 is ignored. Input during DRAIN is not accepted.

## Timing
- Reset values:
  - in_ready_o=1 (combinational from state).
  - wr_valid_o=0, wr_last_o=0, chunk_done_o=0.
  - wr_sparsemap_o=0, wr_nonzero_data_o=0.
  - wr_dat_count_o=0, wr_chunk_count_o=0, chunk_nz_count_o=0.
- Reset mid-operation discards the partial or draining chunk. No chunk_done_o is issued.
- Latency: beat 0 is valid the cycle after the closing input beat is accepted.
- Drain throughput: 1 beat/cycle with wr_ready_i high.
- Minimum chunk period: accepted input beats + CHUNK_BEATS cycles.
- in_ready_o is 0 from the cycle after close until the cycle after the last write handshake.
- chunk_nz_count_o is registered, valid throughout DRAIN, and held until the next close.
- Write-path outputs are registered; counters and flags come straight from flops.

## Structure
- Package sparse_pkg holds:
  - default parameter constants;
  - state enum {FILL, DRAIN};
  - width localparams for counters and the nz count.
- Sub-module sparse_beat_compactor: combinational.
  - Input: one dense beat.
  - Outputs: map bits, left-compacted nonzero beat, popcount via prefix sum.
- Top level holds the FSM, map buffer, packed element buffer with element-granular write-enable, read mask and counters.

## Test plan
Bench config for all scenarios: BUS_SIZE=4, DAT_SIZE=8, CHUNK_BEATS=2, CHUNK_NUM=3.
- Dense chunk: beats {1,2,3,4},{5,6,7,8} -> maps 4'hF,4'hF; data {1,2,3,4},{5,6,7,8}; nz=8; chunk 0; chunk_done_o once.
- Cross-beat packing: {0,5,0,7},{9,0,0,0} -> beat0 map 4'b1010, data {5,7,9,0}; beat1 map 4'b0001, data {0,0,0,0}; nz=3.
- Early last: single beat {0,0,3,0} with in_last_i -> beat0 map 4'b0100, data {3,0,0,0}; beat1 map 0, data 0; nz=1; two write beats still issued.
- Backpressure: wr_ready_i low 3 cycles on beat0 -> outputs stable, in_ready_o=0; then beat1 follows and wr_last_o=1 on beat1 only.
- Counter wrap/clear: 4 chunks -> chunk counts 0,1,2,0; chunk_cnt_clr_i coincident with the final handshake of chunk 1 -> next chunk is 0.
- Reset mid-FILL after 1 accepted beat -> all outputs at reset values; next chunk starts at dat_count 0 with nz 0 and no stale data.
